// File: rtl/uart_cfg_commit_ctrl.sv
// rtl/uart_cfg_commit_ctrl.sv - commits shadowed UART config registers into the UART core
module uart_cfg_commit_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int N_REG          = 4,
    parameter int ADDR_W         = $clog2(N_REG) + 1,
    parameter int NUM_CFG        = 2,
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_req,
    input  logic                  uart_busy,
    input  logic                  update_ok,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  cfg_valid,
    output logic [ADDR_W-1:0]     cfg_addr,
    output logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_ready,
    output logic                  commit_busy,
    output logic                  commit_done,
    output logic                  commit_err,
    output logic [1:0]            err_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_READ,
        S_SEND,
        S_WAIT_OK,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               pending;
    logic [ADDR_W-1:0]  index;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic               tmo;
    logic               read_last;
    logic               last_idx;
    logic               start;

    // cnt doubles as the age-in-state counter, which also paces the READ dwell
    assign tmo       = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign read_last = (READ_LATENCY == 0) || (cnt != '0);
    assign last_idx  = (index == ADDR_W'(NUM_CFG - 1));
    assign start     = (state == S_IDLE) && (state_next == S_WAIT_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (commit_req || pending) state_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!uart_busy)  state_next = S_READ;
                else if (tmo)    state_next = S_ERR;
            end
            S_READ: begin
                if (read_last) state_next = S_SEND;
            end
            S_SEND: begin
                if (cfg_ready)   state_next = last_idx ? S_WAIT_OK : S_READ;
                else if (tmo)    state_next = S_ERR;
            end
            S_WAIT_OK: begin
                if (update_ok)   state_next = S_DONE;
                else if (tmo)    state_next = S_ERR;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_addr     = (state == S_READ) ? index : rd_addr_q;
        cfg_valid   = (state == S_SEND);
        commit_busy = (state != S_IDLE);
        commit_done = (state == S_DONE);
        commit_err  = (state == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pending   <= 1'b0;
            index     <= '0;
            rd_addr_q <= '0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            err_code  <= 2'b00;
        end else begin
            if (state_next != state || state == S_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // Only one request can wait behind an active commit
            if (start) begin
                pending <= 1'b0;
            end else if (commit_req && state != S_IDLE) begin
                pending <= 1'b1;
            end

            if (start) begin
                index <= '0;
            end else if (state == S_SEND && cfg_ready) begin
                index <= index + ADDR_W'(1);
            end

            if (state == S_READ) begin
                rd_addr_q <= index;
            end

            if (state == S_READ && read_last) begin
                cfg_addr <= index;
                cfg_data <= rd_data;
            end

            if (start) begin
                err_code <= 2'b00;
            end else if (state_next == S_ERR) begin
                case (state)
                    S_WAIT_IDLE: err_code <= 2'b01;
                    S_SEND:      err_code <= 2'b10;
                    S_WAIT_OK:   err_code <= 2'b11;
                    default:     err_code <= err_code;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cfg_commit_ctrl.sv
// tb/tb_uart_cfg_commit_ctrl.sv - directed vector bench for uart_cfg_commit_ctrl (read latency 0 and 1)
module tb_uart_cfg_commit_ctrl;

    logic        clk;
    logic        rst;
    logic        commit_req;
    logic        uart_busy;
    logic        update_ok_w   [2];
    logic        cfg_ready_w   [2];
    logic [2:0]  rd_addr_w     [2];
    logic [15:0] rd_data_w     [2];
    logic        cfg_valid_w   [2];
    logic [2:0]  cfg_addr_w    [2];
    logic [15:0] cfg_data_w    [2];
    logic        busy_w        [2];
    logic        done_w        [2];
    logic        err_w         [2];
    logic [1:0]  err_code_w    [2];
    logic [15:0] regs          [4];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_cfg_commit_ctrl #(.DATA_WIDTH(16), .N_REG(4), .NUM_CFG(2), .READ_LATENCY(0), .TIMEOUT_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .commit_req(commit_req), .uart_busy(uart_busy),
        .update_ok(update_ok_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]),
        .cfg_valid(cfg_valid_w[0]), .cfg_addr(cfg_addr_w[0]), .cfg_data(cfg_data_w[0]),
        .cfg_ready(cfg_ready_w[0]), .commit_busy(busy_w[0]), .commit_done(done_w[0]),
        .commit_err(err_w[0]), .err_code(err_code_w[0])
    );

    uart_cfg_commit_ctrl #(.DATA_WIDTH(16), .N_REG(4), .NUM_CFG(2), .READ_LATENCY(1), .TIMEOUT_CYCLES(16)) dut1 (
        .clk(clk), .rst(rst), .commit_req(commit_req), .uart_busy(uart_busy),
        .update_ok(update_ok_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]),
        .cfg_valid(cfg_valid_w[1]), .cfg_addr(cfg_addr_w[1]), .cfg_data(cfg_data_w[1]),
        .cfg_ready(cfg_ready_w[1]), .commit_busy(busy_w[1]), .commit_done(done_w[1]),
        .commit_err(err_w[1]), .err_code(err_code_w[1])
    );

    // Register file: combinational port for dut0, one-cycle registered port for dut1
    always_comb rd_data_w[0] = (rd_addr_w[0] < 3'd4) ? regs[rd_addr_w[0][1:0]] : 16'h0;
    always_ff @(posedge clk) rd_data_w[1] <= (rd_addr_w[1] < 3'd4) ? regs[rd_addr_w[1][1:0]] : 16'h0;

    typedef struct {
        logic [15:0] r0;
        logic [15:0] r1;
        int          busy_n;
        int          stall_n;
        bit          ok_never;
        bit          stray_ok;
        int          lat0;
        int          lat1;
        int          fv0;
        int          fv1;
        int          nx;
        int          v1;
        bit          is_err;
        int          code;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag, input int d);
        check({tag, "_valid"},    32'(cfg_valid_w[d]), 0);
        check({tag, "_busy"},     32'(busy_w[d]), 0);
        check({tag, "_done"},     32'(done_w[d]), 0);
        check({tag, "_err"},      32'(err_w[d]), 0);
        check({tag, "_err_code"}, 32'(err_code_w[d]), 0);
        check({tag, "_rd_addr"},  32'(rd_addr_w[d]), 0);
        check({tag, "_cfg_addr"}, 32'(cfg_addr_w[d]), 0);
        check({tag, "_cfg_data"}, 32'(cfg_data_w[d]), 0);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          done_at [2];
        bit          err_seen[2];
        int          fv      [2];
        int          nx      [2];
        int          v1      [2];
        int          stall_c [2];
        bit          hold    [2];
        logic [2:0]  h_addr  [2];
        logic [15:0] h_data  [2];
        logic [15:0] expd    [2];
        expd[0] = v.r0;
        expd[1] = v.r1;
        regs[0] = v.r0;
        regs[1] = v.r1;
        for (int d = 0; d < 2; d++) begin
            done_at[d] = -1; err_seen[d] = 1'b0; fv[d] = -1; nx[d] = 0;
            v1[d] = 0; stall_c[d] = 0; hold[d] = 1'b0;
        end
        @(negedge clk);
        commit_req = 1'b1;
        uart_busy  = (v.busy_n > 0);
        for (int d = 0; d < 2; d++) begin
            cfg_ready_w[d] = 1'b1;
            update_ok_w[d] = !v.ok_never;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            commit_req = 1'b0;
            uart_busy  = (v.busy_n > 0) && (c <= v.busy_n);
            for (int d = 0; d < 2; d++) begin
                if (cfg_valid_w[d] && fv[d] < 0) fv[d] = c;
                if (cfg_valid_w[d] && cfg_addr_w[d] == 3'd1) v1[d]++;
                if ((done_w[d] || err_w[d]) && done_at[d] < 0) begin
                    done_at[d]  = c;
                    err_seen[d] = err_w[d];
                end
                cfg_ready_w[d] = 1'b1;
                if (cfg_valid_w[d] && cfg_addr_w[d] == 3'd1 && stall_c[d] < v.stall_n) begin
                    cfg_ready_w[d] = 1'b0;
                    stall_c[d]++;
                end
                update_ok_w[d] = v.ok_never ? (v.stray_ok && cfg_valid_w[d]) : 1'b1;
                if (hold[d] && cfg_valid_w[d]) begin
                    check($sformatf("v%0d_d%0d_hold_addr", id, d), 32'(cfg_addr_w[d]), 32'(h_addr[d]));
                    check($sformatf("v%0d_d%0d_hold_data", id, d), 32'(cfg_data_w[d]), 32'(h_data[d]));
                end
                if (cfg_valid_w[d] && cfg_ready_w[d]) begin
                    if (nx[d] < 2) begin
                        check($sformatf("v%0d_d%0d_xfer%0d_addr", id, d, nx[d]), 32'(cfg_addr_w[d]), 32'(nx[d]));
                        check($sformatf("v%0d_d%0d_xfer%0d_data", id, d, nx[d]), 32'(cfg_data_w[d]), 32'(expd[nx[d]]));
                    end
                    nx[d]++;
                end
                hold[d]   = cfg_valid_w[d] && !cfg_ready_w[d];
                h_addr[d] = cfg_addr_w[d];
                h_data[d] = cfg_data_w[d];
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("v%0d_d%0d_latency", id, d), 32'(done_at[d]), 32'(d == 0 ? v.lat0 : v.lat1));
            check($sformatf("v%0d_d%0d_is_err", id, d), 32'(err_seen[d]), 32'(v.is_err));
            check($sformatf("v%0d_d%0d_err_code", id, d), 32'(err_code_w[d]), 32'(v.code));
            check($sformatf("v%0d_d%0d_first_valid", id, d), 32'(fv[d]), 32'(d == 0 ? v.fv0 : v.fv1));
            check($sformatf("v%0d_d%0d_n_xfer", id, d), 32'(nx[d]), 32'(v.nx));
            check($sformatf("v%0d_d%0d_word1_valid_cycles", id, d), 32'(v1[d]), 32'(v.v1));
            check($sformatf("v%0d_d%0d_idle_after", id, d), 32'(busy_w[d]), 0);
        end
    endtask

    initial begin
        int n_done [2];
        int done1  [2];
        int done2  [2];
        bit busy_h [2][48];
        bit found;
        int stray;

        // r0, r1, busy_n, stall_n, ok_never, stray_ok, lat0, lat1, fv0, fv1, nx, v1, is_err, code
        vecs[0] = '{16'h0003, 16'h12C0,    0,    0, 1'b0, 1'b0,  7,  9,  3,  4, 2,  1, 1'b0, 0};
        vecs[1] = '{16'hA5A5, 16'hFFFF,    0,    0, 1'b0, 1'b0,  7,  9,  3,  4, 2,  1, 1'b0, 0};
        vecs[2] = '{16'h0003, 16'h12C0,   10,    0, 1'b0, 1'b0, 17, 19, 13, 14, 2,  1, 1'b0, 0};
        vecs[3] = '{16'h0003, 16'h12C0, 1000,    0, 1'b0, 1'b0, 17, 17, -1, -1, 0,  0, 1'b1, 1};
        vecs[4] = '{16'h0003, 16'h12C0,    0,    5, 1'b0, 1'b0, 12, 14,  3,  4, 2,  6, 1'b0, 0};
        vecs[5] = '{16'h0003, 16'h12C0,    0, 1000, 1'b0, 1'b0, 21, 23,  3,  4, 1, 16, 1'b1, 2};
        vecs[6] = '{16'h0003, 16'h12C0,    0,    0, 1'b1, 1'b1, 22, 24,  3,  4, 2,  1, 1'b1, 3};

        regs[0] = 16'h0003; regs[1] = 16'h12C0; regs[2] = 16'hDEAD; regs[3] = 16'hBEEF;
        rst = 1'b1; commit_req = 1'b0; uart_busy = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cfg_ready_w[d] = 1'b1;
            update_ok_w[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset_d0", 0);
        check_reset_vals("reset_d1", 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Three extra requests during an active commit collapse into one queued commit
        regs[0] = 16'h0003; regs[1] = 16'h12C0;
        @(negedge clk);
        commit_req = 1'b1; uart_busy = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cfg_ready_w[d] = 1'b1; update_ok_w[d] = 1'b1;
            n_done[d] = 0; done1[d] = -1; done2[d] = -1;
        end
        for (int c = 1; c < 48; c++) begin
            @(negedge clk);
            commit_req = (c == 2) || (c == 3) || (c == 4);
            for (int d = 0; d < 2; d++) begin
                busy_h[d][c] = busy_w[d];
                if (done_w[d]) begin
                    n_done[d]++;
                    if (done1[d] < 0) done1[d] = c;
                    else if (done2[d] < 0) done2[d] = c;
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("queue_d%0d_n_done", d), 32'(n_done[d]), 2);
            check($sformatf("queue_d%0d_done1", d), 32'(done1[d]), 32'(d == 0 ? 7 : 9));
            check($sformatf("queue_d%0d_done2", d), 32'(done2[d]), 32'(d == 0 ? 15 : 19));
            if (done1[d] > 0 && done1[d] < 45) begin
                check($sformatf("queue_d%0d_gap_idle", d), 32'(busy_h[d][done1[d] + 1]), 0);
                check($sformatf("queue_d%0d_restart", d), 32'(busy_h[d][done1[d] + 2]), 1);
            end
        end

        // Reset during SEND of the latency-1 instance, with a request queued behind it
        @(negedge clk);
        commit_req = 1'b1;
        for (int d = 0; d < 2; d++) cfg_ready_w[d] = 1'b0;
        @(negedge clk);
        commit_req = 1'b0;
        @(negedge clk);
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (cfg_valid_w[1]) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached_send", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("abort_d1", 1);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) cfg_ready_w[d] = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (busy_w[d] || done_w[d] || err_w[d]) stray++;
            end
        end
        check("abort_no_activity", 32'(stray), 0);
        run_vec(7, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
